// File: rtl/dct_coef_link_pkg.sv
// Shared defaults, read-side FSM states and the coefficient sign-extension helper for dct_coef_link.
// Pure declarations: no logic, no latency.
package dct_coef_link_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_KEEP  = 14;
  localparam int DEF_BLK   = 64;
  localparam int DEF_NBUF  = 2;
  localparam int DEF_CNT_W = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } rd_state_e;

  // Replicates bit keep-1 into every higher bit; callers truncate to their word width.
  function automatic logic [63:0] sext_coef(input logic [63:0] v, input int keep);
    logic [63:0] r;
    logic        sgn;
    sgn = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == keep - 1) sgn = v[i];
    end
    for (int i = 0; i < 64; i++) begin
      r[i] = (i >= keep) ? sgn : v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dct_coef_link_buf.sv
// Block buffer RAM: NBUF*BLK words of KEEP bits, one write and one read port.
// Read data is registered (1 cycle) and holds its value while rd_en is low.
module coef_blk_buf #(
  parameter int W     = 14,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_dat
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_dat_q;
  logic [W-1:0] rd_dat_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_comb begin
    rd_dat_d = rd_en ? mem[rd_addr] : rd_dat_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_dat_q <= '0;
    else       rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/dct_coef_link.sv
// dct -> idct link: keeps coefficient MSBs, ping-pongs whole blocks and replays each as one start burst.
// Last word in at t -> first word out at t+2; no backpressure: words arriving for a busy buffer are dropped.
module dct_coef_link
  import dct_coef_link_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int KEEP  = DEF_KEEP,
  parameter int BLK   = DEF_BLK,
  parameter int NBUF  = DEF_NBUF,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             apx_en,
  input  logic [CNT_W-1:0] apx_lo,
  input  logic [CNT_W-1:0] apx_hi,
  output logic             out_start,
  output logic [DW-1:0]    out_data,
  output logic             rapx,
  output logic             overflow,
  output logic [15:0]      blk_cnt
);

  localparam int IW = $clog2(BLK);
  localparam int BW = $clog2(NBUF);
  localparam int AW = $clog2(NBUF * BLK);
  localparam logic [IW-1:0] LAST_IDX = IW'(BLK - 1);
  localparam logic [BW-1:0] LAST_BUF = BW'(NBUF - 1);

  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [BW-1:0]    wr_buf_q, wr_buf_d;
  logic             blk_drop_q, blk_drop_d;
  logic [NBUF-1:0]  full_q, full_d;
  logic             overflow_q, overflow_d;

  rd_state_e        state_q, state_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic [BW-1:0]    rd_buf_q, rd_buf_d;
  logic             out_start_q, out_start_d;
  logic             rapx_q, rapx_d;
  logic [15:0]      blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic             wr_last, wr_drop, wr_en;
  logic [AW-1:0]    wr_addr;
  logic             rd_done, rd_en, win;
  logic [AW-1:0]    rd_addr;
  logic [KEEP-1:0]  rd_word;
  logic             in_lsb_unused;

  assign in_lsb_unused = ^in_data;

  // Once any word of a block is dropped the rest of that block is dropped too,
  // so a half-written buffer is never marked full and replayed.
  always_comb begin
    wr_last    = (wr_idx_q == LAST_IDX);
    wr_drop    = in_valid && (full_q[wr_buf_q] || blk_drop_q);
    wr_en      = in_valid && !wr_drop;
    wr_addr    = AW'(int'(wr_buf_q) * BLK + int'(wr_idx_q));
    wr_idx_d   = wr_idx_q;
    wr_buf_d   = wr_buf_q;
    blk_drop_d = blk_drop_q;
    overflow_d = overflow_q | wr_drop;
    if (in_valid) begin
      if (wr_last) begin
        wr_idx_d   = '0;
        blk_drop_d = 1'b0;
        if (wr_en) wr_buf_d = (wr_buf_q == LAST_BUF) ? '0 : wr_buf_q + BW'(1);
      end else begin
        wr_idx_d   = wr_idx_q + IW'(1);
        blk_drop_d = blk_drop_q | wr_drop;
      end
    end
    full_d = full_q;
    if (wr_en && wr_last) full_d[wr_buf_q] = 1'b1;
    if (rd_done)          full_d[rd_buf_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx_q   <= '0;
      wr_buf_q   <= '0;
      blk_drop_q <= 1'b0;
      full_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      wr_buf_q   <= wr_buf_d;
      blk_drop_q <= blk_drop_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // The RAM read runs one word ahead: word 0 is fetched in the IDLE cycle that launches the burst.
  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    rd_buf_d    = rd_buf_q;
    out_start_d = out_start_q;
    rapx_d      = rapx_q;
    blk_cnt_d   = blk_cnt_q;
    rd_en       = 1'b0;
    rd_addr     = AW'(int'(rd_buf_q) * BLK + int'(rd_idx_q) + 1);
    rd_done     = (state_q == S_BURST) && (rd_idx_q == LAST_IDX);
    win         = apx_en && (cyc_q > apx_lo) && (cyc_q < apx_hi);
    cyc_d       = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_buf_q]) begin
          state_d     = S_BURST;
          out_start_d = 1'b1;
          rd_idx_d    = '0;
          rapx_d      = ~win;
          rd_en       = 1'b1;
          rd_addr     = AW'(int'(rd_buf_q) * BLK);
        end
      end
      S_BURST: begin
        if (rd_done) begin
          state_d     = S_IDLE;
          out_start_d = 1'b0;
          rd_idx_d    = '0;
          rd_buf_d    = (rd_buf_q == LAST_BUF) ? '0 : rd_buf_q + BW'(1);
          blk_cnt_d   = blk_cnt_q + 16'd1;
        end else begin
          rd_idx_d = rd_idx_q + IW'(1);
          rd_en    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_idx_q    <= '0;
      rd_buf_q    <= '0;
      out_start_q <= 1'b0;
      rapx_q      <= 1'b1;
      blk_cnt_q   <= '0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      rd_buf_q    <= rd_buf_d;
      out_start_q <= out_start_d;
      rapx_q      <= rapx_d;
      blk_cnt_q   <= blk_cnt_d;
      cyc_q       <= cyc_d;
    end
  end

  coef_blk_buf #(
    .W     (KEEP),
    .DEPTH (NBUF * BLK),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (in_data[DW-1 -: KEEP]),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dat  (rd_word)
  );

  always_comb begin
    out_data = out_start_q ? DW'(sext_coef(64'(rd_word), KEEP)) : '0;
  end

  assign out_start = out_start_q;
  assign rapx      = rapx_q;
  assign overflow  = overflow_q;
  assign blk_cnt   = blk_cnt_q;

endmodule
